pipeline_valid_ready: RTL and testbench
=======================================

Name: pipeline_valid_ready

Overview:
- Parametrised successor to the single-bit pipeline_ce_reset.
- Carries a WIDTH-bit data word through STAGES register stages, with a valid/ready handshake on both sides.
- Empty stages (bubbles) collapse; a stalled output back-pressures the input only when every stage is full.
- Used between BCH syndrome/locator/Chien blocks where downstream can stall.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- STAGES, 2, number of register stages (>=0; 0 = combinational pass-through).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
- ce  input  1  clock enable; no transfer or state change while low.
- flush  input  1  synchronous clear of all stage valids, without reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  pipeline accepts the word this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  output word present.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  word from the last stage.
- occupancy  output  $clog2(STAGES+1)  number of valid stages.

Behaviour:
- Each stage k (0..STAGES-1) holds v[k] and d[k]. Stage 0 is input-side; stage STAGES-1 drives out_valid and out_data.
- Advance chain (combinational):
  - adv[STAGES-1] = out_ready & ce.
  - adv[k] = !v[k+1] | adv[k+1].
- Stage k loads from stage k-1 (stage 0 loads from in_*) when ce & (!v[k] | adv[k]).
- v[k] becomes the upstream valid.
- in_ready = ce & (!v[0] | adv[0]).
- out_valid = ce & v[STAGES-1].
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Both may occur in the same cycle.
- Latency: STAGES cycles from input transfer to out_valid, when unstalled.
- Throughput: one word per cycle with out_ready held high.
- Stall: with out_ready=0, words pack forward into empty stages; in_ready drops only once all STAGES are valid.
- Full with out_ready=1: simultaneous push and pop allowed; occupancy unchanged.
- Empty: out_valid=0; out_data is don't-care.
- Data must not change in a stage whose valid is held and not advancing.
- ce=0: all registers hold; in_ready=0; out_valid=0.
- flush (when reset high):
  - All v[k] cleared next cycle, regardless of ce; occupancy=0 next cycle.
  - in_ready and out_valid are forced 0 during the flush cycle, so no transfer occurs.
- Reset (reset=0, regardless of ce or flush):
  - Next cycle: all v=0, occupancy=0, out_valid=0.
  - in_ready=0 while reset is asserted.
  - Mid-stream reset discards in-flight words; no partial word emerges afterwards.
- Priority: reset > flush > ce.
- occupancy is registered and updated as +1 on push only, -1 on pop only, unchanged otherwise.
- STAGES=0: out_valid = in_valid & ce; in_ready = out_ready & ce; out_data = in_data; occupancy fixed at 0 (1-bit wide).
- All register updates use the TCQ=1 delay.

Optional Feature:
- Macro: PIPELINE_VALID_READY_DATA_RESET_EN.
- Defined: d[k] cleared to 0 on reset and on flush; out_data reads 0 after reset.
- Undefined: only valids and occupancy are reset. Data registers carry no reset and have no defined value after reset, which saves reset routing for wide words.
- Handshake behaviour is identical either way.

Decomposition:
- Shared package bch_util_pkg: TCQ constant (1).
- One sub-module, pipeline_valid_ready_stage (WIDTH): a single valid/data register with load-enable and clear. Instantiated STAGES times by generate.
- The advance chain and occupancy counter stay in the top module.

Test Plan:
- Reset: WIDTH=8, STAGES=3, hold reset=0 for 2 cycles -> out_valid=0, occupancy=0, in_ready=0; release -> in_ready=1 next cycle.
- Streaming: push 0x01..0x0A back-to-back with out_ready=1 -> first out_valid 3 cycles after first push, words in order, one per cycle, occupancy steady at 3.
- Back-pressure: out_ready=0, push 0xA5, 0x5A, 0x3C -> occupancy 3, in_ready=0; raise out_ready -> 0xA5, 0x5A, 0x3C emitted in order, no loss or duplication.
- Bubble collapse: push 0x11, idle 2 cycles, push 0x22, out_ready=0 -> both packed in stages 2 and 1, occupancy=2, in_ready=1.
- Flush and ce: with occupancy=3, pulse flush -> occupancy=0, out_valid=0 next cycle. With ce=0 for 4 cycles mid-stream -> no state change, in_ready=0, out_valid=0.
- STAGES=0 and macro: word passes in the same cycle. With PIPELINE_VALID_READY_DATA_RESET_EN defined -> out_data=0x00 after reset.

Source files
------------

// File: rtl/bch_util_pkg.sv
// Shared constants and helpers for the BCH datapath blocks.
package bch_util_pkg;

  localparam int unsigned TCQ = 32'd1;

  // Occupancy counter width; a zero-stage pipeline still exposes a 1-bit port.
  function automatic int occ_width(input int stages);
    return (stages > 32'sd0) ? $clog2(stages + 32'sd1) : 32'sd1;
  endfunction

endpackage

// File: rtl/pipeline_valid_ready_stage.sv
// One valid/data register of the valid/ready pipeline, with load-enable and clear.
// Data clears on reset/flush only when PIPELINE_VALID_READY_DATA_RESET_EN is defined.
module pipeline_valid_ready_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  // Valid bit: reset and clear win over load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_r <= 1'b0;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= up_valid;
    end else begin
      valid_r <= valid_r;
    end
  end

`ifdef PIPELINE_VALID_READY_DATA_RESET_EN
  // Data word with reset/clear to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      data_r <= {WIDTH{1'b0}};
    end else if (load) begin
      data_r <= up_data;
    end else begin
      data_r <= data_r;
    end
  end
`else
  // Data word without reset; only the valid bit says whether it means anything.
  always_ff @(posedge clk) begin
    if (load) begin
      data_r <= up_data;
    end else begin
      data_r <= data_r;
    end
  end
`endif

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/pipeline_valid_ready.sv
// STAGES-deep valid/ready register pipeline with bubble collapse, flush and clock enable.
// Define PIPELINE_VALID_READY_DATA_RESET_EN to clear the data registers on reset/flush.
module pipeline_valid_ready
  import bch_util_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ce,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [occ_width(STAGES)-1:0]    occupancy
);

  localparam int OCC_W = occ_width(STAGES);

  logic run_s;

  // Handshakes are only live while enabled and neither resetting nor flushing.
  assign run_s = ce & reset & ~flush;

  generate
    if (STAGES == 0) begin : g_pass
      assign out_valid = in_valid & run_s;
      assign in_ready  = out_ready & run_s;
      assign out_data  = in_data;
      assign occupancy = {OCC_W{1'b0}};
    end else begin : g_pipe
      logic [STAGES-1:0] v_s;
      logic [STAGES-1:0] adv_s;
      logic [STAGES-1:0] load_s;
      logic [STAGES-1:0] up_v_s;
      logic [WIDTH-1:0]  up_d_s [STAGES];
      logic [WIDTH-1:0]  d_s    [STAGES];
      logic [OCC_W-1:0]  occ_r;
      logic              push_s;
      logic              pop_s;

      // A stage can move on when the stage ahead is empty or is itself moving.
      always_comb begin
        adv_s = {STAGES{1'b0}};
        adv_s[STAGES-1] = out_ready & ce;
        for (int k = STAGES - 2; k >= 0; k--) begin
          adv_s[k] = ~v_s[k+1] | adv_s[k+1];
        end
      end

      assign load_s    = {STAGES{run_s}} & (~v_s | adv_s);
      assign in_ready  = load_s[0];
      assign out_valid = run_s & v_s[STAGES-1];
      assign out_data  = d_s[STAGES-1];
      assign push_s    = in_valid & in_ready;
      assign pop_s     = out_valid & out_ready;

      for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
          assign up_v_s[k] = in_valid;
          assign up_d_s[k] = in_data;
        end else begin : g_link
          assign up_v_s[k] = v_s[k-1];
          assign up_d_s[k] = d_s[k-1];
        end

        pipeline_valid_ready_stage #(
          .WIDTH (WIDTH)
        ) u_stage (
          .clk      (clk),
          .reset    (reset),
          .clear    (flush),
          .load     (load_s[k]),
          .up_valid (up_v_s[k]),
          .up_data  (up_d_s[k]),
          .valid    (v_s[k]),
          .data     (d_s[k])
        );
      end

      // Occupancy tracks accepted minus delivered words.
      always_ff @(posedge clk) begin
        if (!reset) begin
          occ_r <= {OCC_W{1'b0}};
        end else if (flush) begin
          occ_r <= {OCC_W{1'b0}};
        end else if (push_s & ~pop_s) begin
          occ_r <= occ_r + OCC_W'(1);
        end else if (pop_s & ~push_s) begin
          occ_r <= occ_r - OCC_W'(1);
        end else begin
          occ_r <= occ_r;
        end
      end

      assign occupancy = occ_r;
    end
  endgenerate

endmodule

// File: tb/tb_pipeline_valid_ready.sv
// Self-checking bench: directed table, streaming sequence and random traffic against a queue model.
module tb_pipeline_valid_ready;

  localparam int WIDTH = 8;
  localparam int S     = 3;

  logic             clk = 1'b0;
  logic             reset, ce, flush, in_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic             in_ready0, out_valid0;
  logic [WIDTH-1:0] out_data0;
  logic [0:0]       occupancy0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_valid_ready #(.WIDTH(WIDTH), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .ce(ce), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipeline_valid_ready #(.WIDTH(WIDTH), .STAGES(0)) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occupancy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Zero-stage instance is a gated wire.
  task automatic chk_pass0();
    logic run;
    run = ce & reset & ~flush;
    chk("p0_out_valid", {31'd0, out_valid0}, {31'd0, in_valid & run});
    chk("p0_in_ready", {31'd0, in_ready0}, {31'd0, out_ready & run});
    chk("p0_out_data", {24'd0, out_data0}, {24'd0, in_data});
    chk("p0_occupancy", {31'd0, occupancy0}, 32'd0);
  endtask

  // Reference model: words in arrival order, each with its stage position.
  logic [WIDTH-1:0] mq_d[$];
  int               mq_p[$];

  task automatic model_cycle();
    logic run, ov, pop, ir;
    int   np[$];
    int   lim;
    run = ce & reset & ~flush;
    ov  = run && (mq_d.size() > 0) && (mq_p[0] == S - 1);
    pop = ov && out_ready;
    lim = S;
    for (int i = (pop ? 1 : 0); i < mq_p.size(); i++) begin
      np.push_back((mq_p[i] + 1 < lim) ? mq_p[i] + 1 : lim - 1);
      lim = np[np.size() - 1];
    end
    ir = run && (lim > 0);
    chk("m_in_ready", {31'd0, in_ready}, {31'd0, ir});
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, ov});
    chk("m_occupancy", {30'd0, occupancy}, mq_d.size());
    if (ov) chk("m_out_data", {24'd0, out_data}, {24'd0, mq_d[0]});
    if (!reset || flush) begin
      mq_d.delete();
      mq_p.delete();
    end else if (run) begin
      if (pop) void'(mq_d.pop_front());
      mq_p = np;
      if (in_valid && ir) begin
        mq_d.push_back(in_data);
        mq_p.push_back(0);
      end
    end
  endtask

  // ctl = {reset, ce, flush, in_valid, out_ready}; ex = {in_ready, out_valid, occupancy}
  typedef struct {
    logic [4:0]       ctl;
    logic [WIDTH-1:0] din;
    logic [3:0]       ex;
    logic [WIDTH-1:0] edata;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(input logic [4:0] ctl, input logic [7:0] din,
                              input logic [3:0] ex, input logic [7:0] edata);
    vec_t v;
    v.ctl = ctl; v.din = din; v.ex = ex; v.edata = edata;
    return v;
  endfunction

  initial begin
    reset = 1'b0; ce = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;

    // reset, back-pressure, drain
    tbl[0]  = mk(5'b01000, 8'h00, 4'b0000, 8'h00);
    tbl[1]  = mk(5'b01000, 8'h00, 4'b0000, 8'h00);
    tbl[2]  = mk(5'b11010, 8'hA5, 4'b1000, 8'h00);
    tbl[3]  = mk(5'b11010, 8'h5A, 4'b1001, 8'h00);
    tbl[4]  = mk(5'b11010, 8'h3C, 4'b1010, 8'h00);
    tbl[5]  = mk(5'b11010, 8'h77, 4'b0111, 8'hA5);
    tbl[6]  = mk(5'b11001, 8'h00, 4'b1111, 8'hA5);
    tbl[7]  = mk(5'b11001, 8'h00, 4'b1110, 8'h5A);
    tbl[8]  = mk(5'b11001, 8'h00, 4'b1101, 8'h3C);
    tbl[9]  = mk(5'b11001, 8'h00, 4'b1000, 8'h00);
    // bubble collapse
    tbl[10] = mk(5'b11010, 8'h11, 4'b1000, 8'h00);
    tbl[11] = mk(5'b11000, 8'h00, 4'b1001, 8'h00);
    tbl[12] = mk(5'b11000, 8'h00, 4'b1001, 8'h00);
    tbl[13] = mk(5'b11010, 8'h22, 4'b1101, 8'h11);
    tbl[14] = mk(5'b11000, 8'h00, 4'b1110, 8'h11);
    tbl[15] = mk(5'b11000, 8'h00, 4'b1110, 8'h11);
    // fill, ce low for 4 cycles, flush
    tbl[16] = mk(5'b11010, 8'h33, 4'b1110, 8'h11);
    tbl[17] = mk(5'b10011, 8'h44, 4'b0011, 8'h00);
    tbl[18] = mk(5'b10011, 8'h44, 4'b0011, 8'h00);
    tbl[19] = mk(5'b10011, 8'h44, 4'b0011, 8'h00);
    tbl[20] = mk(5'b10011, 8'h44, 4'b0011, 8'h00);
    tbl[21] = mk(5'b11000, 8'h00, 4'b0111, 8'h11);
    tbl[22] = mk(5'b11111, 8'h99, 4'b0011, 8'h00);
    tbl[23] = mk(5'b11001, 8'h00, 4'b1000, 8'h00);
    // mid-stream reset discards the word in flight
    tbl[24] = mk(5'b11011, 8'h55, 4'b1000, 8'h00);
    tbl[25] = mk(5'b01011, 8'h66, 4'b0001, 8'h00);
    tbl[26] = mk(5'b11001, 8'h00, 4'b1000, 8'h00);
    tbl[27] = mk(5'b11001, 8'h00, 4'b1000, 8'h00);
    tbl[28] = mk(5'b11001, 8'h00, 4'b1000, 8'h00);
    tbl[29] = mk(5'b11001, 8'h00, 4'b1000, 8'h00);

    @(posedge clk); #1;

    for (int i = 0; i < 30; i++) begin
      {reset, ce, flush, in_valid, out_ready} = tbl[i].ctl;
      in_data = tbl[i].din;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].ex[3]});
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ex[2]});
      chk($sformatf("tbl%0d_occupancy", i), {30'd0, occupancy}, {30'd0, tbl[i].ex[1:0]});
      if (tbl[i].ex[2]) chk($sformatf("tbl%0d_out_data", i), {24'd0, out_data}, {24'd0, tbl[i].edata});
`ifdef PIPELINE_VALID_READY_DATA_RESET_EN
      if (i == 1) chk("rst_out_data_zero", {24'd0, out_data}, 32'd0);
`endif
      chk_pass0();
      @(posedge clk); #1;
    end

    // Streaming 0x01..0x0A back-to-back, out_ready held high
    for (int c = 0; c < 16; c++) begin
      int pushes, pops;
      reset = 1'b1; ce = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = (c < 10);
      in_data  = 8'(c + 1);
      pushes = (c < 10) ? c : 10;
      pops   = (c < 3) ? 0 : ((c - 3 < 10) ? c - 3 : 10);
      @(negedge clk);
      chk($sformatf("str%0d_out_valid", c), {31'd0, out_valid}, {31'd0, (c >= 3) && (c < 13)});
      if ((c >= 3) && (c < 13)) chk($sformatf("str%0d_out_data", c), {24'd0, out_data}, c - 2);
      chk($sformatf("str%0d_occupancy", c), {30'd0, occupancy}, pushes - pops);
      chk($sformatf("str%0d_in_ready", c), {31'd0, in_ready}, 32'd1);
      chk_pass0();
      @(posedge clk); #1;
    end

    // Random traffic against the queue model
    for (int n = 0; n < 2000; n++) begin
      reset     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      ce        = ($urandom_range(0, 7) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = 8'($urandom);
      @(negedge clk);
      model_cycle();
      chk_pass0();
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
